extmod_regfile: RTL and testbench
=================================

// Module: extmod_regfile
// PURPOSE
//   External (non-ghostbus) bus peripheral: a 2**aw x dw flop-based register file.
//   Synchronous write, combinational read.
//   Sits behind a ghostbus "passenger" port (extmod_foo / extmod_bar).
//   The parent decodes the upper address bits and gates we with its address hit.
//   The parent routes dout straight onto the bus read-data mux with no extra pipeline stage.
// PARAMETERS
//   aw  4  address width; depth = 2**aw words (aw >= 1)
//   dw  8  data width of each word (dw >= 1)
// PORTS
//   clk    input   1   bus clock; all state changes on rising edge
//   rst_n  input   1   reset, asynchronous, active-low
//   addr   input   aw  word address, already relative to the peripheral base
//   din    input   dw  write data
//   dout   output  dw  read data = word at addr (combinational)
//   we     input   1   write enable, sampled on rising clk
// BEHAVIOUR
//   Interface
//   - One clock (clk); reset is asynchronous and active-low (rst_n).
//   Storage
//   - mem[0 .. 2**aw-1], each dw bits, built from individual flops (no RAM inference).
//   Reset
//   - rst_n low -> every word clears to 0 immediately, without waiting for a clock edge.
//   - dout reads 0 at every address while rst_n is low.
//   - we is ignored while rst_n is low.
//   - Release of rst_n is synchronous in effect: the first write can occur on the
//     first rising clk edge where rst_n is high.
//   - A reset asserted mid-operation discards all contents; no partial write survives.
//   Write
//   - On rising clk, if rst_n && we: mem[addr] <= din.
//   - Exactly one word is written per cycle. All other words hold their value.
//   Read
//   - dout = mem[addr] purely combinationally, with zero-cycle latency from addr.
//   - There is no read strobe, and reads have no side effects.
//   Simultaneous read and write to the same address
//   - Before the edge, dout shows the old value.
//   - After the edge, dout shows din, in the same cycle as the update.
//   Width rules
//   - addr covers the whole array, so every address is valid; there is no out-of-range case.
//   - din and dout are exactly dw bits; any zero-extension to the bus width is done by the parent.
//   Handshake
//   - None; the array is always ready and there is no backpressure.
//   - A write completes in 1 cycle; a read completes in 0 cycles.
//   X-handling
//   - An unknown addr or din with we low must not modify state.
// TESTING
//   Use aw=4 and dw=8 unless stated otherwise.
//   1. Reset
//      - Drive rst_n=0 with clk stopped, then sweep addr 0..15.
//      - Required: dout==8'h00 at every address.
//      - Required: a write pulse (we=1) during reset leaves the contents 0.
//   2. Fill and readback
//      - Write din=8'hA0|i to addr i for i=0..15, then read back without further edges.
//      - Required: dout==8'hA0|i per address, with no clock needed between addr change and check.
//   3. Write gating
//      - Write addr 3 = 8'h5C.
//      - Then hold we=0 with din=8'hFF for 4 cycles at addr 3.
//      - Required: dout stays 8'h5C.
//   4. Same-address read during write
//      - At addr 7 (value 8'h11), set din=8'h22 and we=1.
//      - Required: dout==8'h11 before the edge and 8'h22 after it.
//      - Required: neighbouring addresses 6 and 8 are unchanged.
//   5. Reset mid-operation
//      - After filling, pulse rst_n low for 3 ns between clock edges.
//      - Required: all words read 0 immediately.
//      - Required: a write on the next edge after release succeeds.
//   6. Parameter sweep
//      - Repeat scenario 2 with aw=1/dw=1 and aw=6/dw=32 (pattern = address).
//      - Required: exact readback at each configuration.

Source files
------------

// File: rtl/extmod_regfile.sv
// Flop-based 2**aw x dw register file: synchronous write, combinational read.
// Every word clears asynchronously on rst_n; dout follows addr with no latency.
`timescale 1ns / 1ps

module extmod_regfile #(
    parameter int aw = 4,
    parameter int dw = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [aw-1:0] addr,
    input  logic [dw-1:0] din,
    output logic [dw-1:0] dout,
    input  logic          we
);

    localparam int Depth = 1 << aw;

    logic [dw-1:0] mem_q [Depth];

    for (genvar g = 0; g < Depth; g++) begin : g_word
        logic          hit;
        logic [dw-1:0] word_d;

        assign hit = we && (addr == aw'(g));

        always_comb begin
            word_d = mem_q[g];
            if (hit) word_d = din;
        end

        // NOTE: a storage array is reset only because this is a small flop array
        // that must read zero during reset; a real RAM macro has no reset path.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) mem_q[g] <= '0;
            else        mem_q[g] <= word_d;
        end
    end

    assign dout = mem_q[addr];

endmodule

// File: tb/tb_extmod_regfile.sv
// Directed bench for extmod_regfile: reset, fill/readback, gating, same-address
// write, mid-operation reset, and two extra parameterisations.
`timescale 1ns / 1ps

module tb_extmod_regfile;

    logic clk = 1'b0;
    logic clk_run = 1'b0;
    logic rst_n = 1'b1;

    logic [3:0]  addr4 = '0;
    logic [7:0]  din4  = '0;
    logic        we4   = 1'b0;
    logic [7:0]  dout4;

    logic        addr1 = '0;
    logic        din1  = '0;
    logic        we1   = 1'b0;
    logic        dout1;

    logic [5:0]  addr6 = '0;
    logic [31:0] din6  = '0;
    logic        we6   = 1'b0;
    logic [31:0] dout6;

    int n_checks = 0;
    int n_fail   = 0;

    extmod_regfile #(.aw(4), .dw(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .addr(addr4), .din(din4), .dout(dout4), .we(we4)
    );
    extmod_regfile #(.aw(1), .dw(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .addr(addr1), .din(din1), .dout(dout1), .we(we1)
    );
    extmod_regfile #(.aw(6), .dw(32)) dut6 (
        .clk(clk), .rst_n(rst_n), .addr(addr6), .din(din6), .dout(dout6), .we(we6)
    );

    always #5 if (clk_run) clk = ~clk;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] din;
        logic       we;
        logic       edge_after;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[32];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Fill phase writes A0|i (old value 0 visible before each edge), then
        // the read phase sweeps addresses with no clock edge in between.
        for (int i = 0; i < 16; i++) begin
            vecs[i]      = '{addr: 4'(i), din: 8'hA0 | 8'(i), we: 1'b1,
                             edge_after: 1'b1, exp_dout: 8'h00};
            vecs[16 + i] = '{addr: 4'(i), din: 8'h00, we: 1'b0,
                             edge_after: 1'b0, exp_dout: 8'hA0 | 8'(i)};
        end

        // 1. Reset with the clock stopped, then with write pulses during reset
        #1 rst_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            addr4 = 4'(i);
            #1 check("reset_sweep", 32'(dout4), 32'h00);
        end
        clk_run = 1'b1;
        addr4 = 4'd2; din4 = 8'hFF; we4 = 1'b1;
        we1 = 1'b1; din1 = 1'b1; we6 = 1'b1; din6 = 32'hFFFF_FFFF;
        tick();
        tick();
        check("reset_we_ignored", 32'(dout4), 32'h00);
        check("reset_we_ignored_aw1", 32'(dout1), 32'h0);
        check("reset_we_ignored_aw6", dout6, 32'h0);
        we4 = 1'b0; we1 = 1'b0; we6 = 1'b0;
        rst_n = 1'b1;

        // 2. Fill and readback from the vector table
        for (int i = 0; i < 32; i++) begin
            addr4 = vecs[i].addr;
            din4  = vecs[i].din;
            we4   = vecs[i].we;
            #1 check($sformatf("vec%0d", i), 32'(dout4), 32'(vecs[i].exp_dout));
            if (vecs[i].edge_after) tick();
        end
        we4 = 1'b0;

        // 3. Write gating
        addr4 = 4'd3; din4 = 8'h5C; we4 = 1'b1;
        tick();
        we4 = 1'b0; din4 = 8'hFF;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("gate_hold", 32'(dout4), 32'h5C);
        end
        addr4 = 'x; din4 = 'x;
        tick();
        addr4 = 4'd3;
        #1 check("x_inputs_we_low", 32'(dout4), 32'h5C);

        // 4. Same-address read during write
        addr4 = 4'd7; din4 = 8'h11; we4 = 1'b1;
        tick();
        din4 = 8'h22;
        #1 check("rw_before_edge", 32'(dout4), 32'h11);
        tick();
        check("rw_after_edge", 32'(dout4), 32'h22);
        we4 = 1'b0;
        addr4 = 4'd6;
        #1 check("rw_neighbour6", 32'(dout4), 32'hA6);
        addr4 = 4'd8;
        #1 check("rw_neighbour8", 32'(dout4), 32'hA8);

        // 6. Parameter sweep on the other two instances (pattern = address)
        for (int i = 0; i < 2; i++) begin
            addr1 = 1'(i); din1 = 1'(i); we1 = 1'b1;
            tick();
        end
        we1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            addr1 = 1'(i);
            #1 check($sformatf("aw1_read%0d", i), 32'(dout1), 32'(i));
        end
        for (int i = 0; i < 64; i++) begin
            addr6 = 6'(i); din6 = 32'(i); we6 = 1'b1;
            tick();
        end
        we6 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            addr6 = 6'(i);
            #1 check($sformatf("aw6_read%0d", i), dout6, 32'(i));
        end
        addr6 = 6'd63; din6 = 32'hDEAD_BEEF; we6 = 1'b1;
        tick();
        we6 = 1'b0;
        #1 check("aw6_top_word", dout6, 32'hDEAD_BEEF);

        // 5. Reset pulse of 3 ns between clock edges
        tick();
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            addr4 = 4'(i);
            #0.1 check("midreset_sweep", 32'(dout4), 32'h00);
        end
        addr6 = 6'd63;
        #0.1 check("midreset_aw6", dout6, 32'h0);
        #1.3 rst_n = 1'b1;
        addr4 = 4'd5; din4 = 8'h3C; we4 = 1'b1;
        tick();
        we4 = 1'b0;
        check("post_reset_write", 32'(dout4), 32'h3C);
        addr4 = 4'd4;
        #1 check("post_reset_other", 32'(dout4), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
